// File: rtl/ctrl_pipe_hazard.sv
// Control-side pipeline for the 5-stage MIPS core: carries decoded controls ID->EX->MEM->WB,
// detects load-use hazards, resolves branch/jump redirection and selects EX operand forwarding.
module ctrl_pipe_hazard #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned RA_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [1:0]       id_regdst,
    input  logic             id_regwrite,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_aluscr,
    input  logic [1:0]       id_memtoreg,
    input  logic [1:0]       id_aluop,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             ex_zero,
    output logic             stall,
    output logic             flush_ifid,
    output logic [1:0]       pc_src,
    output logic [1:0]       ex_aluop,
    output logic             ex_aluscr,
    output logic             ex_branch,
    output logic [RA_W-1:0]  ex_rs,
    output logic [RA_W-1:0]  ex_rt,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic             wb_regwrite,
    output logic [1:0]       wb_memtoreg,
    output logic [RA_W-1:0]  wb_dest,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            aluscr;
        logic            branch;
        logic [1:0]      memtoreg;
        logic [1:0]      aluop;
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
        logic [RA_W-1:0] dest;
    } ex_t;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic [1:0]      memtoreg;
        logic [RA_W-1:0] dest;
    } mem_t;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic [1:0]      memtoreg;
        logic [RA_W-1:0] dest;
    } wb_t;

    ex_t             ex_q, ex_d;
    mem_t            mem_q, mem_d;
    wb_t             wb_q, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [RA_W-1:0] id_dest;
    logic            uses_rt, lu, taken, jump_go, load_id;

    always_comb begin
        id_dest = id_rt;
        case (id_regdst)
            2'b01:   id_dest = id_rd;
            2'b10:   id_dest = RA_W'(31);
            default: id_dest = id_rt;
        endcase

        uses_rt = ~id_aluscr | id_memwrite;
        lu      = ex_q.valid & ex_q.memread & (ex_q.dest != '0) & id_valid &
                  ((ex_q.dest == id_rs) | ((ex_q.dest == id_rt) & uses_rt));
        taken   = ex_q.valid & ex_q.branch & ex_zero;
        jump_go = id_valid & id_jump & ~taken & ~lu;
        // A taken branch kills the ID instruction; a load-use holds it in ID.
        load_id = id_valid & ~lu & ~taken;

        stall      = ~reset & lu & ~taken;
        flush_ifid = ~reset & (taken | jump_go);
        pc_src     = 2'b00;
        if (!reset) begin
            if (taken)        pc_src = 2'b01;
            else if (jump_go) pc_src = 2'b10;
        end

        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!reset) begin
            if (mem_q.valid && mem_q.regwrite && (mem_q.dest != '0) && (mem_q.dest == ex_q.rs))
                fwd_a = 2'b10;
            else if (wb_q.valid && wb_q.regwrite && (wb_q.dest != '0) && (wb_q.dest == ex_q.rs))
                fwd_a = 2'b01;
            if (mem_q.valid && mem_q.regwrite && (mem_q.dest != '0) && (mem_q.dest == ex_q.rt))
                fwd_b = 2'b10;
            else if (wb_q.valid && wb_q.regwrite && (wb_q.dest != '0) && (wb_q.dest == ex_q.rt))
                fwd_b = 2'b01;
        end

        ex_d = '0;
        if (load_id) begin
            ex_d.valid    = 1'b1;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
            ex_d.memwrite = id_memwrite;
            ex_d.aluscr   = id_aluscr;
            ex_d.branch   = id_branch;
            ex_d.memtoreg = id_memtoreg;
            ex_d.aluop    = id_aluop;
            ex_d.rs       = id_rs;
            ex_d.rt       = id_rt;
            ex_d.dest     = id_dest;
        end

        mem_d.valid    = ex_q.valid;
        mem_d.regwrite = ex_q.regwrite;
        mem_d.memread  = ex_q.memread;
        mem_d.memwrite = ex_q.memwrite;
        mem_d.memtoreg = ex_q.memtoreg;
        mem_d.dest     = ex_q.dest;

        wb_d.valid    = mem_q.valid;
        wb_d.regwrite = mem_q.regwrite;
        wb_d.memtoreg = mem_q.memtoreg;
        wb_d.dest     = mem_q.dest;

        cnt_d = cnt_q;
        if ((lu || taken) && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_aluop     = ex_q.aluop;
    assign ex_aluscr    = ex_q.aluscr;
    assign ex_branch    = ex_q.branch;
    assign ex_rs        = ex_q.rs;
    assign ex_rt        = ex_q.rt;
    assign mem_memread  = mem_q.memread;
    assign mem_memwrite = mem_q.memwrite;
    assign wb_regwrite  = wb_q.regwrite;
    assign wb_memtoreg  = wb_q.memtoreg;
    assign wb_dest      = wb_q.dest;
    assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed bench for ctrl_pipe_hazard; the counter is narrowed so saturation is reachable quickly.
module tb_ctrl_pipe_hazard;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned RA_W  = 5;

    logic             clk, reset, id_valid;
    logic [1:0]       id_regdst, id_memtoreg, id_aluop;
    logic             id_regwrite, id_branch, id_jump, id_memread, id_memwrite, id_aluscr;
    logic [RA_W-1:0]  id_rs, id_rt, id_rd;
    logic             ex_zero;
    logic             stall, flush_ifid;
    logic [1:0]       pc_src, ex_aluop, wb_memtoreg, fwd_a, fwd_b;
    logic             ex_aluscr, ex_branch, mem_memread, mem_memwrite, wb_regwrite;
    logic [RA_W-1:0]  ex_rs, ex_rt, wb_dest;
    logic [CNT_W-1:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    ctrl_pipe_hazard #(.CNT_W(CNT_W), .RA_W(RA_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_regdst(id_regdst),
        .id_regwrite(id_regwrite), .id_branch(id_branch), .id_jump(id_jump),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_aluscr(id_aluscr),
        .id_memtoreg(id_memtoreg), .id_aluop(id_aluop), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .ex_zero(ex_zero), .stall(stall), .flush_ifid(flush_ifid),
        .pc_src(pc_src), .ex_aluop(ex_aluop), .ex_aluscr(ex_aluscr), .ex_branch(ex_branch),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_dest(wb_dest),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [1:0] regdst, input logic regwrite,
                            input logic branch, input logic jump, input logic memread,
                            input logic memwrite, input logic aluscr, input logic [1:0] memtoreg,
                            input logic [1:0] aluop, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd);
        id_valid = v; id_regdst = regdst; id_regwrite = regwrite; id_branch = branch;
        id_jump = jump; id_memread = memread; id_memwrite = memwrite; id_aluscr = aluscr;
        id_memtoreg = memtoreg; id_aluop = aluop; id_rs = rs; id_rt = rt; id_rd = rd;
    endtask

    task automatic nop();
        drive_id(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
    endtask

    // R-type add: rd <- rs + rt
    task automatic add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        drive_id(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, rs, rt, rd);
    endtask

    task automatic do_reset();
        reset = 1'b1; ex_zero = 1'b0;
        nop();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ex_zero = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_id(1'b1, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                     5'($urandom), 5'($urandom), 5'($urandom));
            tick();
        end
        checks++;
        if ({stall, flush_ifid, pc_src, ex_aluop, ex_aluscr, ex_branch, ex_rs, ex_rt, mem_memread,
             mem_memwrite, wb_regwrite, wb_memtoreg, wb_dest, fwd_a, fwd_b, bubble_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_during got stall=%b flush=%b pc_src=%b ex_rs=%0d cnt=%0d exp all 0",
                     stall, flush_ifid, pc_src, ex_rs, bubble_cnt);
        end
        reset = 1'b0; ex_zero = 1'b0;
        nop();
        #1;
        checks++;
        if ({stall, flush_ifid, pc_src, ex_aluop, ex_aluscr, ex_branch, ex_rs, ex_rt, mem_memread,
             mem_memwrite, wb_regwrite, wb_memtoreg, wb_dest, fwd_a, fwd_b, bubble_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_after got stall=%b pc_src=%b wb_dest=%0d cnt=%0d exp all 0",
                     stall, pc_src, wb_dest, bubble_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        // lw $9, 0($1)
        drive_id(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 5'd1, 5'd9, 5'd0);
        tick();
        add(5'd9, 5'd2, 5'd10);
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", stall); end
        tick();
        checks++;
        if ({ex_aluop, ex_aluscr, ex_branch, ex_rs, ex_rt} !== '0) begin
            errors++;
            $display("FAIL lu_bubble got aluop=%b rs=%0d rt=%0d exp 0", ex_aluop, ex_rs, ex_rt);
        end
        checks++;
        if (bubble_cnt !== 8'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", bubble_cnt); end
        tick();
        checks++;
        if (ex_rs !== 5'd9 || fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
            errors++;
            $display("FAIL lu_fwd got rs=%0d fwd_a=%b fwd_b=%b exp 9 01 00", ex_rs, fwd_a, fwd_b);
        end
        checks++;
        if (wb_regwrite !== 1'b1 || wb_dest !== 5'd9 || wb_memtoreg !== 2'b01) begin
            errors++;
            $display("FAIL lu_wb got rw=%b dest=%0d m2r=%b exp 1 9 01",
                     wb_regwrite, wb_dest, wb_memtoreg);
        end
    endtask

    task automatic test_uses_rt();
        do_reset();
        drive_id(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 5'd1, 5'd9, 5'd0);
        tick();
        // addi $3, $9 as rt-destination form: rt not a source, no stall
        drive_id(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 5'd1, 5'd9, 5'd0);
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL imm_nostall got %b exp 0", stall); end
        // sw $9 reads rt
        drive_id(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 5'd1, 5'd9, 5'd0);
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL sw_stall got %b exp 1", stall); end
        do_reset();
        drive_id(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 5'd1, 5'd0, 5'd0);
        tick();
        add(5'd0, 5'd0, 5'd4);
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL lu_r0 got %b exp 0", stall); end
    endtask

    task automatic test_forward();
        do_reset();
        add(5'd1, 5'd2, 5'd8);
        tick();
        add(5'd8, 5'd8, 5'd3);
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL fwd_nostall got %b exp 0", stall); end
        tick();
        nop();
        #1;
        checks++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
            errors++; $display("FAIL fwd_mem got a=%b b=%b exp 10 10", fwd_a, fwd_b);
        end
        do_reset();
        add(5'd1, 5'd2, 5'd8);
        tick();
        nop();
        tick();
        add(5'd8, 5'd8, 5'd3);
        tick();
        nop();
        #1;
        checks++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
            errors++; $display("FAIL fwd_wb got a=%b b=%b exp 01 01", fwd_a, fwd_b);
        end
        do_reset();
        add(5'd1, 5'd2, 5'd0);
        tick();
        add(5'd0, 5'd0, 5'd3);
        tick();
        nop();
        #1;
        checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            errors++; $display("FAIL fwd_r0 got a=%b b=%b exp 00 00", fwd_a, fwd_b);
        end
        do_reset();
        add(5'd1, 5'd2, 5'd8);
        tick();
        add(5'd1, 5'd2, 5'd8);
        tick();
        add(5'd8, 5'd4, 5'd5);
        tick();
        nop();
        #1;
        checks++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
            errors++; $display("FAIL fwd_prio got a=%b b=%b exp 10 00", fwd_a, fwd_b);
        end
    endtask

    task automatic beq();
        drive_id(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 5'd1, 5'd2, 5'd0);
    endtask

    task automatic test_branch();
        do_reset();
        beq();
        tick();
        add(5'd3, 5'd4, 5'd5);
        ex_zero = 1'b1;
        #1;
        checks++;
        if (pc_src !== 2'b01 || flush_ifid !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL br_taken got pc_src=%b flush=%b stall=%b exp 01 1 0",
                     pc_src, flush_ifid, stall);
        end
        tick();
        ex_zero = 1'b0;
        checks++;
        if (ex_branch !== 1'b0 || ex_rs !== 5'd0 || bubble_cnt !== 8'd1) begin
            errors++;
            $display("FAIL br_kill got br=%b rs=%0d cnt=%0d exp 0 0 1", ex_branch, ex_rs, bubble_cnt);
        end
        do_reset();
        beq();
        tick();
        add(5'd3, 5'd4, 5'd5);
        #1;
        checks++;
        if (pc_src !== 2'b00 || flush_ifid !== 1'b0) begin
            errors++; $display("FAIL br_nt got pc_src=%b flush=%b exp 00 0", pc_src, flush_ifid);
        end
        tick();
        checks++;
        if (ex_rs !== 5'd3 || ex_branch !== 1'b0 || bubble_cnt !== 8'd0) begin
            errors++;
            $display("FAIL br_nt_adv got rs=%0d br=%b cnt=%0d exp 3 0 0", ex_rs, ex_branch, bubble_cnt);
        end
    endtask

    task automatic test_jal();
        do_reset();
        drive_id(1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 5'd0, 5'd0, 5'd0);
        #1;
        checks++;
        if (pc_src !== 2'b10 || flush_ifid !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL jal_redirect got pc_src=%b flush=%b exp 10 1", pc_src, flush_ifid);
        end
        tick();
        nop();
        tick();
        tick();
        checks++;
        if (wb_regwrite !== 1'b1 || wb_dest !== 5'd31 || wb_memtoreg !== 2'b10) begin
            errors++;
            $display("FAIL jal_wb got rw=%b dest=%0d m2r=%b exp 1 31 10",
                     wb_regwrite, wb_dest, wb_memtoreg);
        end
    endtask

    task automatic test_priority();
        do_reset();
        // EX instruction that is both a taken branch and a load to $9
        drive_id(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 5'd1, 5'd9, 5'd0);
        tick();
        drive_id(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd9, 5'd0, 5'd0);
        ex_zero = 1'b1;
        #1;
        checks++;
        if (pc_src !== 2'b01 || stall !== 1'b0 || flush_ifid !== 1'b1) begin
            errors++;
            $display("FAIL prio_taken got pc_src=%b stall=%b flush=%b exp 01 0 1",
                     pc_src, stall, flush_ifid);
        end
        tick();
        ex_zero = 1'b0;
        nop();
        #1;
        checks++;
        if (pc_src !== 2'b00 || bubble_cnt !== 8'd1) begin
            errors++; $display("FAIL prio_kill got pc_src=%b cnt=%0d exp 00 1", pc_src, bubble_cnt);
        end
        do_reset();
        drive_id(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 5'd1, 5'd9, 5'd0);
        tick();
        drive_id(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd9, 5'd0, 5'd0);
        #1;
        checks++;
        if (stall !== 1'b1 || pc_src !== 2'b00 || flush_ifid !== 1'b0) begin
            errors++;
            $display("FAIL jump_defer got stall=%b pc_src=%b flush=%b exp 1 00 0",
                     stall, pc_src, flush_ifid);
        end
        tick();
        checks++;
        if (stall !== 1'b0 || pc_src !== 2'b10 || flush_ifid !== 1'b1) begin
            errors++;
            $display("FAIL jump_resume got stall=%b pc_src=%b flush=%b exp 0 10 1",
                     stall, pc_src, flush_ifid);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 258; i++) begin
            beq();
            tick();
            ex_zero = 1'b1;
            nop();
            tick();
            ex_zero = 1'b0;
            if (i == 253) begin
                checks++;
                if (bubble_cnt !== 8'd254) begin
                    errors++; $display("FAIL sat_count got %0d exp 254", bubble_cnt);
                end
            end
        end
        checks++;
        if (bubble_cnt !== 8'hFF) begin errors++; $display("FAIL sat_hold got %0h exp ff", bubble_cnt); end
    endtask

    initial begin
        reset = 1'b1;
        ex_zero = 1'b0;
        nop();
        test_reset();
        test_load_use();
        test_uses_rt();
        test_forward();
        test_branch();
        test_jal();
        test_priority();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
